// File: rtl/pdomain_pkg.sv
// Shared types for the processing domain: run-control state encoding and
// synchroniser depth.
package pdomain_pkg;

    typedef enum logic [1:0] {
        PD_SCRUB = 2'd0,
        PD_HALT  = 2'd1,
        PD_RUN   = 2'd2,
        PD_DRAIN = 2'd3
    } pd_state_t;

    localparam int unsigned PD_SYNC_STAGES = 2;

endpackage

// File: rtl/pd_regfile.sv
// Register file: NREGS x XLEN, one write port, NPORTS registered read ports.
// A read of the index being written in the same cycle returns the new data.
module pd_regfile
    import pdomain_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NPORTS = 3,
    parameter int unsigned RW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we,
    input  logic [RW-1:0]          wsel,
    input  logic [XLEN-1:0]        wdata,
    input  logic [NPORTS*RW-1:0]   rsel,
    output logic [NPORTS*XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [NREGS];

    // Storage array; contents are cleared by the scrub sequence, not by reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wsel] <= wdata;
        end
    end

    // Registered read ports with write-through bypass
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                rdata[i*XLEN +: XLEN] <= (we && (wsel == rsel[i*RW +: RW])) ?
                                         wdata : mem[rsel[i*RW +: RW]];
            end
        end
    end

endmodule

// File: rtl/pdomain.sv
// Processing domain: pc_inhibit synchroniser, scrub/halt/run/drain run control,
// register-file write arbitration and an optional halted-only debug port.
// Define PDOMAIN_DBG_EN to enable the debug port; otherwise its outputs are 0.
module pdomain
    import pdomain_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    localparam int unsigned RW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pc_inhibit,
    input  logic                core_idle,
    output logic                core_run,
    output logic [1:0]          state,
    output logic                scrub_done,
    input  logic                wb_valid,
    input  logic [RW-1:0]       wb_sel,
    input  logic [XLEN-1:0]     wb_data,
    output logic                wb_ready,
    input  logic [NRD*RW-1:0]   rd_sel,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                dbg_valid,
    input  logic                dbg_we,
    input  logic [RW-1:0]       dbg_sel,
    input  logic [XLEN-1:0]     dbg_wdata,
    output logic                dbg_ready,
    output logic [XLEN-1:0]     dbg_rdata,
    output logic                dbg_rvalid
);

`ifdef PDOMAIN_DBG_EN
    localparam bit DbgEn = 1'b1;
`else
    localparam bit DbgEn = 1'b0;
`endif

    pd_state_t                 state_q;
    logic [RW-1:0]             scrub_cnt_q;
    logic                      scrub_done_q;
    logic                      core_run_q;
    logic                      wb_ready_q;
    logic                      dbg_ready_q;
    logic                      dbg_rvalid_q;
    logic [PD_SYNC_STAGES-1:0] sync_q;
    logic                      inh_s;
    logic                      dbg_rd;
    logic                      dbg_wr;
    logic                      rf_we;
    logic [RW-1:0]             rf_wsel;
    logic [XLEN-1:0]           rf_wdata;
    logic [(NRD+1)*XLEN-1:0]   rf_rdata;

    assign inh_s  = sync_q[PD_SYNC_STAGES-1];
    // dbg_ready_q is only ever set in HALT with the debug port enabled
    assign dbg_wr = dbg_valid & dbg_ready_q & dbg_we;
    assign dbg_rd = dbg_valid & dbg_ready_q & ~dbg_we;

    // Synchronise pc_inhibit; resets to "inhibited"
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[PD_SYNC_STAGES-2:0], pc_inhibit};
        end
    end

    // Run-control FSM; outputs are registered alongside the state they decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PD_SCRUB;
            scrub_cnt_q  <= '0;
            scrub_done_q <= 1'b0;
            core_run_q   <= 1'b0;
            wb_ready_q   <= 1'b0;
            dbg_ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                PD_SCRUB: begin
                    if (scrub_cnt_q == RW'(NREGS - 1)) begin
                        state_q      <= PD_HALT;
                        scrub_done_q <= 1'b1;
                        dbg_ready_q  <= DbgEn;
                    end else begin
                        scrub_cnt_q <= scrub_cnt_q + 1'b1;
                    end
                end
                PD_HALT: begin
                    if (!inh_s) begin
                        state_q     <= PD_RUN;
                        core_run_q  <= 1'b1;
                        wb_ready_q  <= 1'b1;
                        dbg_ready_q <= 1'b0;
                    end
                end
                PD_RUN: begin
                    if (inh_s) begin
                        state_q    <= PD_DRAIN;
                        core_run_q <= 1'b0;
                    end
                end
                PD_DRAIN: begin
                    // Always via HALT, even if inhibit has already dropped
                    if (core_idle) begin
                        state_q     <= PD_HALT;
                        wb_ready_q  <= 1'b0;
                        dbg_ready_q <= DbgEn;
                    end
                end
            endcase
        end
    end

    // Debug read data is valid for exactly the cycle after acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_rvalid_q <= 1'b0;
        end else begin
            dbg_rvalid_q <= dbg_rd;
        end
    end

    // Single write port: source is selected by state, which makes sources exclusive
    always_comb begin
        rf_we    = 1'b0;
        rf_wsel  = '0;
        rf_wdata = '0;
        unique case (state_q)
            PD_SCRUB: begin
                rf_we   = 1'b1;
                rf_wsel = scrub_cnt_q;
            end
            PD_HALT: begin
                rf_we    = dbg_wr;
                rf_wsel  = dbg_sel;
                rf_wdata = dbg_wdata;
            end
            PD_RUN, PD_DRAIN: begin
                rf_we    = wb_valid;
                rf_wsel  = wb_sel;
                rf_wdata = wb_data;
            end
        endcase
    end

    pd_regfile #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NPORTS (NRD + 1),
        .RW     (RW)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (rf_we),
        .wsel    (rf_wsel),
        .wdata   (rf_wdata),
        .rsel    ({dbg_sel, rd_sel}),
        .rdata   (rf_rdata)
    );

    assign state      = state_q;
    assign core_run   = core_run_q;
    assign scrub_done = scrub_done_q;
    assign wb_ready   = wb_ready_q;
    assign rd_data    = rf_rdata[NRD*XLEN-1:0];
    assign dbg_ready  = dbg_ready_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = DbgEn ? rf_rdata[NRD*XLEN +: XLEN] : '0;

endmodule

// File: tb/tb_pdomain.sv
// Testbench for pdomain: directed scenarios plus randomized traffic checked
// against a behavioural model of the register file and run control.
module tb_pdomain;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int RW    = 5;

`ifdef PDOMAIN_DBG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    localparam int M_SCRUB = 0;
    localparam int M_HALT  = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                pc_inhibit;
    logic                core_idle;
    logic                core_run;
    logic [1:0]          state;
    logic                scrub_done;
    logic                wb_valid;
    logic [RW-1:0]       wb_sel;
    logic [XLEN-1:0]     wb_data;
    logic                wb_ready;
    logic [NRD*RW-1:0]   rd_sel;
    logic [NRD*XLEN-1:0] rd_data;
    logic                dbg_valid;
    logic                dbg_we;
    logic [RW-1:0]       dbg_sel;
    logic [XLEN-1:0]     dbg_wdata;
    logic                dbg_ready;
    logic [XLEN-1:0]     dbg_rdata;
    logic                dbg_rvalid;

    int checks = 0;
    int passed = 0;

    // Behavioural model
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_known [NREGS];
    int              m_mode;
    int              m_scrubbed;
    bit              m_done;
    bit              m_inh_hist [2];
    logic [XLEN-1:0] e_rd [NRD];
    bit              e_rd_known [NRD];
    bit              e_rvalid;
    logic [XLEN-1:0] e_dbg;

    pdomain #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc_inhibit (pc_inhibit),
        .core_idle  (core_idle),
        .core_run   (core_run),
        .state      (state),
        .scrub_done (scrub_done),
        .wb_valid   (wb_valid),
        .wb_sel     (wb_sel),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .dbg_valid  (dbg_valid),
        .dbg_we     (dbg_we),
        .dbg_sel    (dbg_sel),
        .dbg_wdata  (dbg_wdata),
        .dbg_ready  (dbg_ready),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_status();
        return {2'(m_mode), m_mode == M_RUN, (m_mode == M_RUN) || (m_mode == M_DRAIN),
                DBG && (m_mode == M_HALT), m_done, e_rvalid};
    endfunction

    task automatic model_reset();
        m_mode = M_SCRUB;
        m_scrubbed = 0;
        m_done = 1'b0;
        m_inh_hist[0] = 1'b1;
        m_inh_hist[1] = 1'b1;
        for (int i = 0; i < NREGS; i++) m_known[i] = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            e_rd[i] = '0;
            e_rd_known[i] = 1'b1;
        end
        e_rvalid = 1'b0;
        e_dbg = '0;
    endtask

    // One clock edge of the specified behaviour, using the inputs held before it
    task automatic model_edge();
        bit inh_seen;
        if (m_mode == M_SCRUB) begin
            m_mem[m_scrubbed] = '0;
            m_known[m_scrubbed] = 1'b1;
        end else if (m_mode == M_HALT) begin
            if (DBG && dbg_valid && dbg_we) begin
                m_mem[dbg_sel] = dbg_wdata;
                m_known[dbg_sel] = 1'b1;
            end
        end else if (wb_valid) begin
            m_mem[wb_sel] = wb_data;
            m_known[wb_sel] = 1'b1;
        end
        for (int i = 0; i < NRD; i++) begin
            e_rd[i] = m_mem[rd_sel[i*RW +: RW]];
            e_rd_known[i] = m_known[rd_sel[i*RW +: RW]];
        end
        e_rvalid = DBG && (m_mode == M_HALT) && dbg_valid && !dbg_we;
        if (e_rvalid) e_dbg = m_mem[dbg_sel];
        // inhibit level seen by the FSM is the pin value from two edges earlier
        inh_seen = m_inh_hist[0];
        m_inh_hist[0] = m_inh_hist[1];
        m_inh_hist[1] = pc_inhibit;
        case (m_mode)
            M_SCRUB: begin
                m_scrubbed++;
                if (m_scrubbed == NREGS) begin
                    m_mode = M_HALT;
                    m_done = 1'b1;
                end
            end
            M_HALT:  if (!inh_seen) m_mode = M_RUN;
            M_RUN:   if (inh_seen) m_mode = M_DRAIN;
            default: if (core_idle) m_mode = M_HALT;
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        pc_inhibit = 1'b1;
        core_idle = 1'b0;
        wb_valid = 1'b0;
        wb_sel = '0;
        wb_data = '0;
        rd_sel = '0;
        dbg_valid = 1'b0;
        dbg_we = 1'b0;
        dbg_sel = '0;
        dbg_wdata = '0;
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({state, core_run, wb_ready, dbg_ready, scrub_done, dbg_rvalid} !== 7'b0)
            $display("FAIL reset_status: got %b want %b",
                     {state, core_run, wb_ready, dbg_ready, scrub_done, dbg_rvalid}, 7'b0);
        else passed++;
        checks++;
        if (rd_data !== '0 || dbg_rdata !== '0)
            $display("FAIL reset_data: got rd %h dbg %h want 0", rd_data, dbg_rdata);
        else passed++;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_scrub();
        repeat (NREGS - 1) cycle();
        checks++;
        if (scrub_done !== 1'b0 || state !== 2'd0)
            $display("FAIL scrub_busy: got done %b state %0d want 0 0", scrub_done, state);
        else passed++;
        cycle();
        checks++;
        if (scrub_done !== 1'b1 || state !== 2'd1)
            $display("FAIL scrub_end: got done %b state %0d want 1 1", scrub_done, state);
        else passed++;
        for (int r = 0; r < NREGS; r += 2) begin
            rd_sel = {5'(r + 1), 5'(r)};
            cycle();
            checks++;
            if (rd_data !== '0)
                $display("FAIL scrub_zero r%0d: got %h want 0", r, rd_data);
            else passed++;
        end
    endtask

    task automatic test_run_wb();
        pc_inhibit = 1'b0;
        cycle();
        cycle();
        checks++;
        if (core_run !== 1'b0)
            $display("FAIL run_early: got core_run %b want 0", core_run);
        else passed++;
        cycle();
        checks++;
        if ({state, core_run, wb_ready} !== {2'd2, 1'b1, 1'b1})
            $display("FAIL run_enter: got %b want %b", {state, core_run, wb_ready}, 4'b1011);
        else passed++;
        wb_valid = 1'b1;
        wb_sel = 5'd5;
        wb_data = 64'hDEADBEEF;
        rd_sel = {5'd5, 5'd0};
        cycle();
        checks++;
        if (rd_data[XLEN +: XLEN] !== 64'hDEADBEEF)
            $display("FAIL wb_bypass: got %h want %h", rd_data[XLEN +: XLEN], 64'hDEADBEEF);
        else passed++;
        wb_valid = 1'b0;
        rd_sel = {5'd0, 5'd5};
        cycle();
        checks++;
        if (rd_data[XLEN-1:0] !== 64'hDEADBEEF)
            $display("FAIL wb_read: got %h want %h", rd_data[XLEN-1:0], 64'hDEADBEEF);
        else passed++;
    endtask

    task automatic test_drain();
        pc_inhibit = 1'b1;
        core_idle = 1'b0;
        repeat (3) cycle();
        checks++;
        if ({state, core_run, wb_ready} !== {2'd3, 1'b0, 1'b1})
            $display("FAIL drain_enter: got %b want %b", {state, core_run, wb_ready}, 4'b1101);
        else passed++;
        wb_valid = 1'b1;
        wb_sel = 5'd9;
        wb_data = 64'hA5A5_0000_5A5A;
        rd_sel = {5'd0, 5'd9};
        cycle();
        checks++;
        if (rd_data[XLEN-1:0] !== 64'hA5A5_0000_5A5A || state !== 2'd3)
            $display("FAIL drain_wb: got %h state %0d want %h state 3",
                     rd_data[XLEN-1:0], state, 64'hA5A5_0000_5A5A);
        else passed++;
        wb_valid = 1'b0;
        core_idle = 1'b1;
        cycle();
        checks++;
        if ({state, core_run, wb_ready} !== {2'd1, 1'b0, 1'b0})
            $display("FAIL drain_exit: got %b want %b", {state, core_run, wb_ready}, 4'b0100);
        else passed++;
    endtask

    task automatic test_debug();
        logic [XLEN-1:0] exp7;
        exp7 = DBG ? 64'h1234 : 64'h0;
        dbg_valid = 1'b1;
        dbg_we = 1'b1;
        dbg_sel = 5'd7;
        dbg_wdata = 64'h1234;
        checks++;
        if (dbg_ready !== DBG)
            $display("FAIL dbg_ready_halt: got %b want %b", dbg_ready, DBG);
        else passed++;
        cycle();
        dbg_we = 1'b0;
        cycle();
        checks++;
        if (dbg_rvalid !== DBG || dbg_rdata !== exp7)
            $display("FAIL dbg_read: got v %b d %h want v %b d %h",
                     dbg_rvalid, dbg_rdata, DBG, exp7);
        else passed++;
        dbg_valid = 1'b0;
        cycle();
        checks++;
        if (dbg_rvalid !== 1'b0)
            $display("FAIL dbg_pulse: got %b want 0", dbg_rvalid);
        else passed++;
        pc_inhibit = 1'b0;
        repeat (3) cycle();
        dbg_valid = 1'b1;
        dbg_we = 1'b1;
        dbg_wdata = 64'hFFFF;
        checks++;
        if (dbg_ready !== 1'b0 || state !== 2'd2)
            $display("FAIL dbg_ready_run: got %b state %0d want 0 state 2", dbg_ready, state);
        else passed++;
        cycle();
        dbg_valid = 1'b0;
        rd_sel = {5'd0, 5'd7};
        cycle();
        checks++;
        if (rd_data[XLEN-1:0] !== exp7)
            $display("FAIL dbg_run_ignored: got %h want %h", rd_data[XLEN-1:0], exp7);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(11) == 0) pc_inhibit = ~pc_inhibit;
            core_idle = 1'($urandom_range(3) == 0);
            wb_valid = 1'($urandom);
            wb_sel = 5'($urandom);
            wb_data = {$urandom, $urandom};
            rd_sel = 10'($urandom);
            if ($urandom_range(3) == 0) rd_sel[RW-1:0] = wb_sel;
            dbg_valid = 1'($urandom);
            dbg_we = 1'($urandom);
            dbg_sel = ($urandom_range(1) == 0) ? rd_sel[RW-1:0] : 5'($urandom);
            dbg_wdata = {$urandom, $urandom};
            cycle();
            checks++;
            if ({state, core_run, wb_ready, dbg_ready, scrub_done, dbg_rvalid} !== exp_status())
                $display("FAIL rand_status n%0d: got %b want %b", n,
                         {state, core_run, wb_ready, dbg_ready, scrub_done, dbg_rvalid},
                         exp_status());
            else passed++;
            for (int i = 0; i < NRD; i++) begin
                if (e_rd_known[i]) begin
                    checks++;
                    if (rd_data[i*XLEN +: XLEN] !== e_rd[i])
                        $display("FAIL rand_rd%0d n%0d: got %h want %h", i, n,
                                 rd_data[i*XLEN +: XLEN], e_rd[i]);
                    else passed++;
                end
            end
            if (e_rvalid || !DBG) begin
                checks++;
                if (dbg_rdata !== (DBG ? e_dbg : 64'h0))
                    $display("FAIL rand_dbg n%0d: got %h want %h", n, dbg_rdata,
                             DBG ? e_dbg : 64'h0);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        pc_inhibit = 1'b0;
        core_idle = 1'b1;
        wb_valid = 1'b0;
        dbg_valid = 1'b0;
        repeat (6) cycle();
        checks++;
        if (state !== 2'd2)
            $display("FAIL mid_run: got state %0d want 2", state);
        else passed++;
        wb_valid = 1'b1;
        wb_sel = 5'd5;
        wb_data = 64'h55;
        cycle();
        wb_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({state, core_run, wb_ready, dbg_ready, scrub_done, dbg_rvalid} !== 7'b0 ||
            rd_data !== '0 || dbg_rdata !== '0)
            $display("FAIL mid_reset: got %b rd %h dbg %h want all 0",
                     {state, core_run, wb_ready, dbg_ready, scrub_done, dbg_rvalid},
                     rd_data, dbg_rdata);
        else passed++;
        cycle();
        reset_n = 1'b1;
        repeat (NREGS) cycle();
        checks++;
        if (state !== 2'd1 || scrub_done !== 1'b1)
            $display("FAIL rescrub: got state %0d done %b want 1 1", state, scrub_done);
        else passed++;
        rd_sel = {5'd5, 5'd5};
        cycle();
        checks++;
        if (rd_data !== '0)
            $display("FAIL rescrub_r5: got %h want 0", rd_data);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_scrub();
        test_run_wb();
        test_drain();
        test_debug();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
